// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: two async read ports, one sync write port, plus a valid/ready dump engine.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-through forwarding on the read ports.
module mips_regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              signal_reg_write,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;

  logic [DATA_W-1:0] regs [DEPTH];
  dump_state_t       state;
  dump_state_t       next_state;
  logic              write_en;
  logic [ADDR_W-1:0] next_idx;

  assign write_en = signal_reg_write && (write_reg != '0);
  assign next_idx = dump_idx + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = regs[read_reg_1];
`ifdef REGFILE_BYPASS_EN
    if (write_en && (read_reg_1 == write_reg)) begin
      read_data_1 = write_data;
    end
`endif
    if (read_reg_1 == '0) begin
      read_data_1 = '0;
    end
  end

  always_comb begin
    read_data_2 = regs[read_reg_2];
`ifdef REGFILE_BYPASS_EN
    if (write_en && (read_reg_2 == write_reg)) begin
      read_data_2 = write_data;
    end
`endif
    if (read_reg_2 == '0) begin
      read_data_2 = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (dump_start) next_state = DUMP;
      DUMP: if (dump_ready && (dump_idx == LAST_IDX)) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The beat is a registered snapshot; it only advances on a handshake, and the
  // next beat picks up a write landing on that same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if ((state == IDLE) && dump_start) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if ((state == DUMP) && dump_ready && (dump_idx != LAST_IDX)) begin
      dump_idx  <= next_idx;
      dump_data <= (write_en && (write_reg == next_idx)) ? write_data : regs[next_idx];
    end
  end

  assign dump_valid = (state == DUMP);
  assign dump_busy  = (state != IDLE);
  assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_mips_regfile_param.sv
// Directed self-checking bench for mips_regfile_param (default 32 x 32 configuration).
module tb_mips_regfile_param;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic        dump_start;
  logic        dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int checkCount = 0;
  int errorCount = 0;

  mips_regfile_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_reg(write_reg), .write_data(write_data),
    .signal_reg_write(signal_reg_write),
    .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clocked write, enable dropped afterwards.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    write_reg        = addr;
    write_data       = data;
    signal_reg_write = 1'b1;
    tick();
    signal_reg_write = 1'b0;
  endtask

  initial begin
    int  expIdx;
    bit  seenDone;
    bit  hs;
    reset = 1'b1;
    read_reg_1 = '0; read_reg_2 = '0;
    write_reg = '0; write_data = '0; signal_reg_write = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i);
      #1;
      checkOutput("rst_rd1", read_data_1, 32'h0);
      checkOutput("rst_rd2", read_data_2, 32'h0);
    end
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, dump_valid}, 32'h0);
    checkOutput("rst_busy",  {31'b0, dump_busy},  32'h0);
    checkOutput("rst_done",  {31'b0, dump_done},  32'h0);
    checkOutput("rst_idx",   {27'b0, dump_idx},   32'h0);
    checkOutput("rst_data",  dump_data,           32'h0);

    applyStimulus(5'd5, 32'hDEADBEEF);
    read_reg_1 = 5'd5;
    #1;
    checkOutput("wr_r5", read_data_1, 32'hDEADBEEF);

    // Write to reg 0 must be dropped, even combinationally.
    write_reg = 5'd0; write_data = 32'hFFFFFFFF; signal_reg_write = 1'b1;
    read_reg_2 = 5'd0;
    #1;
    checkOutput("r0_same_cycle", read_data_2, 32'h0);
    tick();
    signal_reg_write = 1'b0;
    checkOutput("r0_after", read_data_2, 32'h0);

    write_reg = 5'd7; write_data = 32'h12345678; signal_reg_write = 1'b1;
    read_reg_1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("hazard_r7", read_data_1, 32'h12345678);
`else
    checkOutput("hazard_r7", read_data_1, 32'h0);
`endif
    tick();
    signal_reg_write = 1'b0;
    checkOutput("hazard_r7_after", read_data_1, 32'h12345678);

    for (int i = 1; i < 32; i++) applyStimulus(5'(i), 32'(i * 4));

    // Full dump with the consumer always ready.
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      checkOutput("full_valid", {31'b0, dump_valid}, 32'h1);
      checkOutput("full_idx",   {27'b0, dump_idx},   32'(b));
      checkOutput("full_data",  dump_data,           32'(b * 4));
      tick();
    end
    checkOutput("full_done",     {31'b0, dump_done},  32'h1);
    checkOutput("full_valid_lo", {31'b0, dump_valid}, 32'h0);
    checkOutput("full_busy_done",{31'b0, dump_busy},  32'h1);
    tick();
    checkOutput("full_done_lo",  {31'b0, dump_done},  32'h0);
    checkOutput("full_busy_lo",  {31'b0, dump_busy},  32'h0);

    // Backpressure: hold beats, overwrite the held register, ignore a restart.
    dump_ready = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    checkOutput("bp_hold0", {27'b0, dump_idx}, 32'h0);
    dump_ready = 1'b1; tick();
    dump_ready = 1'b0; tick();
    checkOutput("bp_hold1", {27'b0, dump_idx}, 32'h1);
    dump_ready = 1'b1; tick(); tick();
    dump_ready = 1'b0;
    checkOutput("bp_idx3",  {27'b0, dump_idx}, 32'h3);
    checkOutput("bp_data3", dump_data, 32'h0000000C);
    applyStimulus(5'd3, 32'h000000AA);
    checkOutput("bp_held_after_wr", dump_data, 32'h0000000C);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    checkOutput("bp_restart_idx",  {27'b0, dump_idx},  32'h3);
    checkOutput("bp_restart_busy", {31'b0, dump_busy}, 32'h1);
    checkOutput("bp_restart_data", dump_data, 32'h0000000C);
    dump_ready = 1'b1;
    tick();
    expIdx = 4;
    seenDone = 1'b0;
    for (int c = 0; c < 200 && !seenDone; c++) begin
      dump_ready = c[0];
      if (dump_valid) begin
        checkOutput("bp_idx",  {27'b0, dump_idx}, 32'(expIdx));
        checkOutput("bp_data", dump_data, 32'(expIdx * 4));
      end
      hs = dump_valid && dump_ready;
      tick();
      if (hs) expIdx++;
      if (dump_done) seenDone = 1'b1;
    end
    checkOutput("bp_done_seen", {31'b0, seenDone}, 32'h1);
    checkOutput("bp_beats", 32'(expIdx), 32'd32);
    tick();
    checkOutput("bp_done_pulse", {31'b0, dump_done}, 32'h0);
    checkOutput("bp_idle",       {31'b0, dump_busy}, 32'h0);

    // Second dump shows the updated register 3.
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick(); tick();
    checkOutput("dump2_idx3",  {27'b0, dump_idx}, 32'h3);
    checkOutput("dump2_data3", dump_data, 32'h000000AA);
    for (int c = 0; c < 100 && dump_busy; c++) tick();
    checkOutput("dump2_finished", {31'b0, dump_busy}, 32'h0);

    // Third dump: same-edge write forwarded into the next beat, then reset at beat 10.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick();
    checkOutput("dump3_idx2", {27'b0, dump_idx}, 32'h2);
    applyStimulus(5'd3, 32'h00000055);
    checkOutput("dump3_fwd_idx",  {27'b0, dump_idx}, 32'h3);
    checkOutput("dump3_fwd_data", dump_data, 32'h00000055);
    for (int c = 0; c < 7; c++) tick();
    checkOutput("dump3_idx10", {27'b0, dump_idx}, 32'd10);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'b0, dump_valid}, 32'h0);
    checkOutput("mid_rst_busy",  {31'b0, dump_busy},  32'h0);
    checkOutput("mid_rst_done",  {31'b0, dump_done},  32'h0);
    checkOutput("mid_rst_data",  dump_data,           32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst_done", {31'b0, dump_done}, 32'h0);
    checkOutput("post_rst_busy", {31'b0, dump_busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i);
      #1;
      checkOutput("post_rst_rd1", read_data_1, 32'h0);
      checkOutput("post_rst_rd2", read_data_2, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
